// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ID/EX operand mux, the execute ALU and the EX/MEM register.
// The slave modport is the ALU; the master modport is the producer/consumer side.
interface alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int OP_W    = 8
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [SHAMT_W-1:0] in_sa;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_zero;
  logic               out_ov;

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_sa, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ov
  );

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_sa, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ov
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, iterative 1-bit-per-cycle shifter,
// registered result with zero and signed-overflow flags behind a valid/ready handshake.
//
//   state | meaning
//   IDLE  | no op in flight, output empty, ready for a new op
//   SHIFT | iterative shift running, cnt_q steps left
//   HOLD  | result presented on out_*, waiting for out_ready
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int OP_W    = 8
) (
  input  logic           clk,
  input  logic           resetn,
  alu_exec_unit_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(8'h24);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8'h25);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8'h26);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(8'h27);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8'h7C);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8'h2A);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(8'h20);
  localparam logic [OP_W-1:0] OP_ADDU = OP_W'(8'h21);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8'h22);
  localparam logic [OP_W-1:0] OP_SUBU = OP_W'(8'h23);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ov_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [OP_W-1:0]    shop_q;

  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   diff_d;
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_ov_d;
  logic [WIDTH-1:0]   shreg_d;
  logic               is_shift_d;
  logic               accept_d;

  // out_ready -> in_ready is combinational so a held result can be replaced back-to-back.
  assign bus.in_ready   = !bus.flush && (state_q == IDLE || (state_q == HOLD && bus.out_ready));
  assign accept_d       = bus.in_valid && bus.in_ready;
  assign is_shift_d     = (bus.in_op == OP_SLL) || (bus.in_op == OP_SRL) || (bus.in_op == OP_SRA);

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_ov     = ov_q;

  assign sum_d  = bus.in_a + bus.in_b;
  assign diff_d = bus.in_a - bus.in_b;

  always_comb begin
    alu_res_d = '0;
    alu_ov_d  = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        alu_res_d = sum_d;
        alu_ov_d  = (bus.in_a[MSB] == bus.in_b[MSB]) && (sum_d[MSB] != bus.in_a[MSB]);
      end
      OP_SUB: begin
        alu_res_d = diff_d;
        alu_ov_d  = (bus.in_a[MSB] != bus.in_b[MSB]) && (diff_d[MSB] != bus.in_a[MSB]);
      end
      OP_ADDU: alu_res_d = sum_d;
      OP_SUBU: alu_res_d = diff_d;
      OP_AND:  alu_res_d = bus.in_a & bus.in_b;
      OP_OR:   alu_res_d = bus.in_a | bus.in_b;
      OP_XOR:  alu_res_d = bus.in_a ^ bus.in_b;
      OP_NOR:  alu_res_d = ~(bus.in_a | bus.in_b);
      OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      // Only reached with a zero shift amount: the operand passes through unchanged.
      OP_SLL, OP_SRL, OP_SRA: alu_res_d = bus.in_b;
      default: alu_res_d = '0;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    case (shop_q)
      OP_SLL:  shreg_d = shreg_q << 1;
      OP_SRL:  shreg_d = shreg_q >> 1;
      default: shreg_d = {shreg_q[MSB], shreg_q[MSB:1]};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ov_q     <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      shop_q   <= '0;
    end else if (bus.flush) begin
      // Result and flags are left as they were; they are meaningless while valid is low.
      state_q <= IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= shreg_d;
            zero_q   <= (shreg_d == '0);
            ov_q     <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end
        end
        default: begin
          if (accept_d) begin
            if (is_shift_d && (bus.in_sa != '0)) begin
              shreg_q <= bus.in_b;
              cnt_q   <= bus.in_sa;
              shop_q  <= bus.in_op;
              valid_q <= 1'b0;
              state_q <= SHIFT;
            end else begin
              result_q <= alu_res_d;
              zero_q   <= (alu_res_d == '0);
              ov_q     <= alu_ov_d;
              valid_q  <= 1'b1;
              state_q  <= HOLD;
            end
          end else if (state_q == HOLD && bus.out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases with literal expectations plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_alu_exec_unit;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OPS [14] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                      OP_SLT, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, 8'hFF, 8'h00};
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5), .OP_W(8)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5), .OP_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one pending op with a cycle countdown, one presented result.
  logic        m_valid = 1'b0;
  logic [31:0] m_res   = '0;
  logic        m_ov    = 1'b0;
  int          pend_left = 0;
  logic [31:0] p_res   = '0;
  logic        p_ov    = 1'b0;

  function automatic void ref_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sa, output logic [31:0] r, output logic ov,
                                 output int lat);
    longint s;
    r = '0; ov = 1'b0; lat = 0;
    case (op)
      OP_ADD:  begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; ov = (s > SMAX) || (s < SMIN); end
      OP_SUB:  begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; ov = (s > SMAX) || (s < SMIN); end
      OP_ADDU: r = a + b;
      OP_SUBU: r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL:  begin r = b << sa; lat = int'(sa); end
      OP_SRL:  begin r = b >> sa; lat = int'(sa); end
      OP_SRA:  begin r = 32'($signed(b) >>> sa); lat = int'(sa); end
      default: r = '0;
    endcase
  endfunction

  function automatic logic exp_ready();
    return !bus.flush && ((pend_left == 0 && !m_valid) || (m_valid && bus.out_ready));
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    logic        n_valid, n_ov, n_pov, ov, acc;
    logic [31:0] n_res, n_pres, r;
    int          n_pend, lat;
    if (!resetn) begin
      m_valid   <= 1'b0;
      m_res     <= '0;
      m_ov      <= 1'b0;
      pend_left <= 0;
    end else begin
      n_valid = m_valid; n_res = m_res; n_ov = m_ov;
      n_pend = pend_left; n_pres = p_res; n_pov = p_ov;
      if (bus.flush) begin
        n_valid = 1'b0;
        n_pend  = 0;
      end else begin
        acc = bus.in_valid && exp_ready();
        if (m_valid && bus.out_ready) n_valid = 1'b0;
        if (pend_left > 0) begin
          n_pend = pend_left - 1;
          if (n_pend == 0) begin n_valid = 1'b1; n_res = p_res; n_ov = p_ov; end
        end
        if (acc) begin
          ref_op(bus.in_op, bus.in_a, bus.in_b, bus.in_sa, r, ov, lat);
          if (lat == 0) begin n_valid = 1'b1; n_res = r; n_ov = ov; end
          else begin n_pend = lat; n_pres = r; n_pov = ov; end
        end
      end
      m_valid <= n_valid; m_res <= n_res; m_ov <= n_ov;
      pend_left <= n_pend; p_res <= n_pres; p_ov <= n_pov;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk("model_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid && bus.out_valid) begin
        chk("model_result", bus.out_result, m_res);
        chk("model_zero", 32'(bus.out_zero), 32'(m_res == 32'd0));
        chk("model_ov", 32'(bus.out_ov), 32'(m_ov));
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
    bit got = 0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_sa = sa;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        got = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!got) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] res, input logic zero, input logic ov);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_result"}, bus.out_result, res);
    chk({name, "_zero"}, 32'(bus.out_zero), 32'(zero));
    chk({name, "_ov"}, 32'(bus.out_ov), 32'(ov));
  endtask

  task automatic drain();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit acc, got;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.in_sa = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a long shift
    issue(OP_ADD, 32'd1, 32'd1, 5'd0);
    expect_out("add_pre", 32'd2, 1'b0, 1'b0);
    issue(OP_SRL, 32'd0, 32'hF000_0000, 5'd20);
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd1);
    chk("rst_out_result", bus.out_result, 32'd0);
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Overflow cases
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    expect_out("add_ov", 32'h8000_0000, 1'b0, 1'b1);
    issue(OP_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0);
    expect_out("addu", 32'h8000_0000, 1'b0, 1'b0);
    issue(OP_SUB, 32'h8000_0000, 32'd1, 5'd0);
    expect_out("sub_ov", 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Iterative shifts, max and zero amount
    issue(OP_SRA, 32'd0, 32'h8000_0000, 5'd31);
    wait_valid(n);
    chk("sra_latency", 32'(n), 32'd31);
    expect_out("sra", 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(OP_SRL, 32'd0, 32'h8000_0000, 5'd31);
    wait_valid(n);
    chk("srl_latency", 32'(n), 32'd31);
    expect_out("srl", 32'h0000_0001, 1'b0, 1'b0);
    issue(OP_SLL, 32'd0, 32'h0000_1234, 5'd0);
    wait_valid(n);
    chk("sll0_latency", 32'(n), 32'd0);
    expect_out("sll0", 32'h0000_1234, 1'b0, 1'b0);

    // Backpressure with a queued op
    drain();
    bus.out_ready = 1'b0;
    issue(OP_SUB, 32'd5, 32'd7, 5'd0);
    bus.in_valid = 1'b1; bus.in_op = OP_AND; bus.in_a = 32'hFF00_FF00; bus.in_b = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      expect_out("bp_hold", 32'hFFFF_FFFE, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    expect_out("bp_and", 32'h0F00_0F00, 1'b0, 1'b0);

    // Flush during a shift, then flush against a valid op
    drain();
    issue(OP_SLL, 32'd0, 32'd1, 5'd10);
    repeat (2) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("flush_no_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_a = 32'd1; bus.in_b = 32'd2; bus.in_sa = '0;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush_no_accept", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("after_flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    expect_out("after_flush_add", 32'd3, 1'b0, 1'b0);

    // Compare, zero result, unknown op
    issue(OP_SUB, 32'd9, 32'd9, 5'd0);
    expect_out("sub_zero", 32'd0, 1'b1, 1'b0);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    expect_out("slt", 32'd1, 1'b0, 1'b0);
    issue(8'hFF, 32'd5, 32'd6, 5'd0);
    expect_out("op_ff", 32'd0, 1'b1, 1'b0);

    // Randomized back-to-back traffic
    for (int k = 0; k < 100; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op = OPS[$urandom_range(0, 13)];
      bus.in_a  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      bus.in_b  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      bus.in_sa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.flush     = ($urandom_range(0, 40) == 0);
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        got = acc;
      end
      bus.flush = 1'b0;
      if (!got) chk("rand_accept_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
